// File: rtl/sync_fifo_buf.sv
// Single-clock elastic FIFO with counters, threshold flags and sticky errors; any DEPTH >= 2.
// Latency: 1-cycle registered read (standard) or prefetched head word when SYNC_FIFO_FWFT_EN is defined.
// Backpressure: writes are dropped while full and reads while empty; each drop sets a sticky error flag.
module sync_fifo_buf #(
    parameter int DW        = 8,
    parameter int DEPTH     = 90,
    parameter int AF_THRESH = 80,
    parameter int AE_THRESH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DW-1:0]                wr_data,
    input  logic                         rd_en,
    output logic [DW-1:0]                rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    input  logic                         err_clr,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_LVL   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   AE_LVL   = (AW+1)'(AE_THRESH);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_inc;
    logic [AW-1:0] rd_ptr_inc;
    logic [AW-1:0] rd_ptr_nxt;
    logic [AW:0]   count_nxt;
    logic          wr_acc;
    logic          rd_acc;

    // Accept decisions, wrapped pointer increments and next occupancy.
    always_comb begin
        wr_acc     = wr_en & ~full;
        rd_acc     = rd_en & ~empty;
        wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        rd_ptr_inc = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        rd_ptr_nxt = rd_acc ? rd_ptr_inc : rd_ptr;
        count_nxt  = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
    end

    // Storage array: written only on an accepted write, never reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, flags from next count, sticky errors and the read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr_inc;
            end
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == CNT_MAX);
            almost_empty <= (count_nxt <= AE_LVL);
            almost_full  <= (count_nxt >= AF_LVL);
            // A new error event outranks a simultaneous clear.
            overflow     <= (wr_en & full)  | (overflow  & ~err_clr);
            underflow    <= (rd_en & empty) | (underflow & ~err_clr);
`ifdef SYNC_FIFO_FWFT_EN
            // Prefetch the next head; when it is being written this cycle take it from wr_data.
            rd_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                if (wr_acc && (wr_ptr == rd_ptr_nxt)) begin
                    rd_data <= wr_data;
                end else begin
                    rd_data <= mem[rd_ptr_nxt];
                end
            end
`else
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
`endif
        end
    end

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Bench for sync_fifo_buf: queue-based reference model checked every cycle plus directed literal checks.
// Latency: outputs sampled 1 time unit after each rising edge (literals) and on falling edges (model).
// Backpressure: overflow/underflow and full/empty rejection exercised directly.
module tb_sync_fifo_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 90;
    localparam int AFT   = 80;
    localparam int AET   = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_buf #(.DW(DW), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] q[$];
    logic          m_live = 1'b0;
    logic          m_ovf  = 1'b0;
    logic          m_udf  = 1'b0;
    logic          m_rdv  = 1'b0;
    logic [DW-1:0] m_rdd  = '0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_live = 1'b1;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_rdv  = 1'b0;
            m_rdd  = '0;
        end else begin
            automatic bit was_full  = (q.size() == DEPTH);
            automatic bit was_empty = (q.size() == 0);
            automatic bit wa = wr_en && !was_full;
            automatic bit ra = rd_en && !was_empty;
            m_ovf = (wr_en && was_full)  ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
            m_udf = (rd_en && was_empty) ? 1'b1 : (err_clr ? 1'b0 : m_udf);
`ifndef SYNC_FIFO_FWFT_EN
            m_rdv = ra;
            if (ra) m_rdd = q[0];
`endif
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(wr_data);
`ifdef SYNC_FIFO_FWFT_EN
            m_rdv = (q.size() != 0);
            if (q.size() != 0) m_rdd = q[0];
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model once per cycle.
    always @(negedge clk) begin
        if (m_live) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_full",  32'(full),  32'(q.size() == DEPTH));
            chk("m_afull", 32'(almost_full),  32'(q.size() >= AFT));
            chk("m_aempty", 32'(almost_empty), 32'(q.size() <= AET));
            chk("m_ovf", 32'(overflow),  32'(m_ovf));
            chk("m_udf", 32'(underflow), 32'(m_udf));
            chk("m_rdvalid", 32'(rd_valid), 32'(m_rdv));
`ifdef SYNC_FIFO_FWFT_EN
            if (m_rdv) chk("m_rddata", 32'(rd_data), 32'(m_rdd));
`else
            chk("m_rddata", 32'(rd_data), 32'(m_rdd));
`endif
        end
    end

    // One clock of stimulus; returns 1 time unit after the edge it applied to.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c, input logic rs);
        @(negedge clk);
        wr_en = w; wr_data = d; rd_en = r; err_clr = c; rst = rs;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
    endtask

    initial begin
        // Reset then idle
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rdvalid", 32'(rd_valid), 0);
        chk("rst_rddata", 32'(rd_data), 0);
        chk("rst_errs", 32'({overflow, underflow}), 0);
        cyc(0, 0, 0, 0, 0);

        // Fill to full, then one rejected write
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            if (i == 79) chk("af_at79", 32'(almost_full), 0);
            if (i == 80) chk("af_at80", 32'(almost_full), 1);
            if (i == 89) chk("full_at89", 32'(full), 0);
        end
        chk("full_at90", 32'(full), 1);
        chk("count_90", 32'(count), 90);
        cyc(1, 8'hFF, 0, 0, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("count_after_ovf", 32'(count), 90);

        // Read back 0x01..0x5A
        for (int i = 1; i <= DEPTH; i++) begin
`ifndef SYNC_FIFO_FWFT_EN
            cyc(0, 0, 1, 0, 0);
            chk("readback", 32'(rd_data), 32'(i));
`else
            chk("readback_head", 32'(rd_data), 32'(i));
            cyc(0, 0, 1, 0, 0);
`endif
            if (i == 81) chk("ae_at9", 32'(almost_empty), 0);
            if (i == 82) chk("ae_at8", 32'(almost_empty), 1);
        end
        chk("drained_empty", 32'(empty), 1);
        cyc(0, 0, 0, 1, 0);
        chk("ovf_cleared", 32'(overflow), 0);

        // Wrap-around: write 60, read 60, write 60, read 60
        for (int i = 0; i < 60; i++) cyc(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 60; i++) cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 60; i++) cyc(1, 8'(8'h80 + i), 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
`ifndef SYNC_FIFO_FWFT_EN
            cyc(0, 0, 1, 0, 0);
            chk("wrap_data", 32'(rd_data), 32'(8'(8'h80 + i)));
`else
            chk("wrap_head", 32'(rd_data), 32'(8'(8'h80 + i)));
            cyc(0, 0, 1, 0, 0);
`endif
        end
        chk("wrap_count0", 32'(count), 0);
        chk("wrap_empty", 32'(empty), 1);

        // Simultaneous access at count 45
        for (int i = 0; i < 45; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(8'hC0 + i), 1, 0, 0);
            chk("sim45_count", 32'(count), 45);
`ifndef SYNC_FIFO_FWFT_EN
            chk("sim45_order", 32'(rd_data), 32'(8'(8'h40 + i)));
`endif
        end
        // Fill up, then read+write while full
        for (int i = 0; i < 45; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
        chk("full_again", 32'(full), 1);
        cyc(1, 8'hEE, 1, 0, 0);
        chk("fullrw_count", 32'(count), 89);
        chk("fullrw_ovf", 32'(overflow), 1);
        for (int i = 0; i < 89; i++) cyc(0, 0, 1, 0, 0);
        chk("empty_again", 32'(empty), 1);
        // Read+write while empty
        cyc(1, 8'h77, 1, 0, 0);
        chk("emptyrw_count", 32'(count), 1);
        chk("emptyrw_udf", 32'(underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("emptyrw_novalid", 32'(rd_valid), 0);
`endif
        cyc(0, 0, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("pop_77", 32'(rd_data), 32'h77);
`endif
        // Clear coinciding with a new underflow: set wins; overflow clears
        cyc(0, 0, 1, 1, 0);
        chk("clr_vs_set_udf", 32'(underflow), 1);
        chk("clr_ovf", 32'(overflow), 0);
        cyc(0, 0, 0, 1, 0);
        chk("clr_udf", 32'(underflow), 0);

        // Reset mid-operation
        for (int i = 0; i < 30; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        cyc(1, 8'hA5, 0, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
        cyc(0, 0, 1, 0, 0);
        chk("a5_data", 32'(rd_data), 32'hA5);
        chk("a5_valid", 32'(rd_valid), 1);
        cyc(0, 0, 0, 0, 0);
        chk("a5_pulse_end", 32'(rd_valid), 0);
        chk("a5_hold", 32'(rd_data), 32'hA5);
`else
        chk("a5_head", 32'(rd_data), 32'hA5);
        cyc(0, 0, 1, 0, 0);
        // Fall-through of a write into an empty FIFO
        cyc(1, 8'h3C, 0, 0, 0);
        chk("fwft_valid", 32'(rd_valid), 1);
        chk("fwft_data", 32'(rd_data), 32'h3C);
        cyc(0, 0, 1, 0, 0);
        chk("fwft_pop_valid", 32'(rd_valid), 0);
        // Write and pop the last entry in the same cycle
        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h22, 1, 0, 0);
        chk("fwft_swap_valid", 32'(rd_valid), 1);
        chk("fwft_swap_data", 32'(rd_data), 32'h22);
        cyc(0, 0, 1, 0, 0);
`endif
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
